// File: rtl/alu_seq_unit.sv
// alu_seq_unit: 64-bit ALU with a request/response handshake.
// Single-cycle ops (AND, OR, ADD, SUB, PASSB) and illegal opcodes respond one cycle after accept.
// MUL (if MUL_EN) runs a 64-step LSB-first shift-add and responds 65 cycles after accept.
//
// Ports:
//   CLK        rising-edge clock
//   Reset_L    synchronous active-low reset
//   ReqValid   request offered; ReqReady high only while idle
//   BusA/BusB  operands, ALUCtrl opcode; all sampled only on accept
//   RespValid  result held until RespReady
//   BusW       registered result; Zero = (BusW == 0); Err = illegal opcode
module alu_seq_unit #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [63:0] BusA,
  input  logic [63:0] BusB,
  input  logic [3:0]  ALUCtrl,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [63:0] BusW,
  output logic        Zero,
  output logic        Err
);

  localparam logic [3:0] OpAnd   = 4'h0;
  localparam logic [3:0] OpOr    = 4'h1;
  localparam logic [3:0] OpAdd   = 4'h2;
  localparam logic [3:0] OpMul   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h6;
  localparam logic [3:0] OpPassB = 4'h7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      r_state;
  logic [63:0] r_a;       // multiplicand, shifted left each step
  logic [63:0] r_b;       // multiplier, shifted right each step
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic [63:0] r_busw;
  logic        r_zero;
  logic        r_err;

  state_e      w_state_next;
  logic [63:0] w_a_next;
  logic [63:0] w_b_next;
  logic [63:0] w_acc_next;
  logic [5:0]  w_cnt_next;
  logic [63:0] w_busw_next;
  logic        w_zero_next;
  logic        w_err_next;

  logic [63:0] w_alu_res;
  logic        w_illegal;
  logic        w_is_mul;
  logic [63:0] w_acc_step;

  // Single-cycle datapath; illegal opcodes produce a zero result.
  always_comb begin
    w_alu_res = '0;
    w_illegal = 1'b0;
    case (ALUCtrl)
      OpAnd:   w_alu_res = BusA & BusB;
      OpOr:    w_alu_res = BusA | BusB;
      OpAdd:   w_alu_res = BusA + BusB;
      OpSub:   w_alu_res = BusA - BusB;
      OpPassB: w_alu_res = BusB;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_is_mul   = MUL_EN && (ALUCtrl == OpMul);
  assign w_acc_step = r_acc + (r_b[0] ? r_a : 64'd0);

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_busw_next  = r_busw;
    w_zero_next  = r_zero;
    w_err_next   = r_err;
    case (r_state)
      StIdle: begin
        if (ReqValid) begin
          if (w_is_mul) begin
            w_a_next     = BusA;
            w_b_next     = BusB;
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_state_next = StCalc;
          end else begin
            w_busw_next  = w_alu_res;
            w_zero_next  = (w_alu_res == 64'd0);
            w_err_next   = w_illegal;
            w_state_next = StDone;
          end
        end
      end
      StCalc: begin
        w_acc_next = w_acc_step;
        w_a_next   = r_a << 1;
        w_b_next   = r_b >> 1;
        w_cnt_next = r_cnt + 6'd1;
        // Step 64 folds straight into the result register.
        if (r_cnt == 6'd63) begin
          w_busw_next  = w_acc_step;
          w_zero_next  = (w_acc_step == 64'd0);
          w_err_next   = 1'b0;
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (RespReady) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busw  <= '0;
      r_zero  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_busw  <= w_busw_next;
      r_zero  <= w_zero_next;
      r_err   <= w_err_next;
    end
  end

  assign ReqReady  = (r_state == StIdle);
  assign RespValid = (r_state == StDone);
  assign BusW      = r_busw;
  assign Zero      = r_zero;
  assign Err       = r_err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with a result scoreboard; a second instance has MUL disabled.
module tb_alu_seq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l;
  logic        req_valid, req_ready, resp_valid, resp_ready, zero, err;
  logic [63:0] bus_a, bus_b, bus_w;
  logic [3:0]  ctrl;
  logic        req_valid0, req_ready0, resp_valid0, resp_ready0, zero0, err0;
  logic [63:0] bus_a0, bus_b0, bus_w0;
  logic [3:0]  ctrl0;

  alu_seq_unit #(.MUL_EN(1'b1)) u_dut (
    .CLK(clk), .Reset_L(rst_l), .ReqValid(req_valid), .ReqReady(req_ready),
    .BusA(bus_a), .BusB(bus_b), .ALUCtrl(ctrl), .RespValid(resp_valid),
    .RespReady(resp_ready), .BusW(bus_w), .Zero(zero), .Err(err)
  );

  alu_seq_unit #(.MUL_EN(1'b0)) u_dut_nomul (
    .CLK(clk), .Reset_L(rst_l), .ReqValid(req_valid0), .ReqReady(req_ready0),
    .BusA(bus_a0), .BusB(bus_b0), .ALUCtrl(ctrl0), .RespValid(resp_valid0),
    .RespReady(resp_ready0), .BusW(bus_w0), .Zero(zero0), .Err(err0)
  );

  typedef struct {
    logic [63:0] w;
    logic        z;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input bit mul_en);
    exp_t r;
    r.e = 1'b0;
    r.w = '0;
    case (op)
      4'h0: r.w = a & b;
      4'h1: r.w = a | b;
      4'h2: r.w = a + b;
      4'h6: r.w = a - b;
      4'h7: r.w = b;
      4'h3: if (mul_en) r.w = a * b; else r.e = 1'b1;
      default: r.e = 1'b1;
    endcase
    r.z = (r.w == 64'd0);
    return r;
  endfunction

  // Offer one request; leaves the bench at the negedge after the accept edge.
  task automatic send(input bit sel, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input exp_t e);
    int n = 0;
    while ((sel ? req_ready0 : req_ready) !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_send", {63'd0, (sel ? req_ready0 : req_ready)}, 64'd1);
    if (sel) begin
      req_valid0 = 1'b1; bus_a0 = a; bus_b0 = b; ctrl0 = op;
    end else begin
      req_valid = 1'b1; bus_a = a; bus_b = b; ctrl = op;
    end
    @(negedge clk);
    acc_cyc = cyc;
    // Scramble inputs right after accept: they must not matter any more.
    if (sel) begin
      req_valid0 = 1'b0; bus_a0 = {$urandom, $urandom}; bus_b0 = {$urandom, $urandom}; ctrl0 = 4'h2;
    end else begin
      req_valid = 1'b0; bus_a = {$urandom, $urandom}; bus_b = {$urandom, $urandom}; ctrl = 4'h2;
    end
    sb.push_back(e);
  endtask

  // Wait for a response, check latency and value, hold it for 'hold' cycles, then consume it.
  task automatic recv(input bit sel, input string tag, input int exp_lat, input int hold);
    int   n = 0;
    exp_t e;
    while ((sel ? resp_valid0 : resp_valid) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {63'd0, (sel ? resp_valid0 : resp_valid)}, 64'd1);
    chk({tag, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_w"}, sel ? bus_w0 : bus_w, e.w);
      chk({tag, "_hold_ready"}, {63'd0, (sel ? req_ready0 : req_ready)}, 64'd0);
      chk({tag, "_hold_valid"}, {63'd0, (sel ? resp_valid0 : resp_valid)}, 64'd1);
      if (sel) begin
        req_valid0 = ~req_valid0; bus_a0 = {$urandom, $urandom}; bus_b0 = ~bus_b0;
      end else begin
        req_valid = ~req_valid; bus_a = {$urandom, $urandom}; bus_b = ~bus_b;
      end
      @(negedge clk);
    end
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    chk({tag, "_w"}, sel ? bus_w0 : bus_w, e.w);
    chk({tag, "_zero"}, {63'd0, (sel ? zero0 : zero)}, {63'd0, e.z});
    chk({tag, "_err"}, {63'd0, (sel ? err0 : err)}, {63'd0, e.e});
    if (sel) resp_ready0 = 1'b1; else resp_ready = 1'b1;
    @(negedge clk);
    resp_ready  = 1'b0;
    resp_ready0 = 1'b0;
    chk({tag, "_idle_after"}, {63'd0, (sel ? req_ready0 : req_ready)}, 64'd1);
    chk({tag, "_w_retained"}, sel ? bus_w0 : bus_w, e.w);
  endtask

  initial begin
    exp_t        e;
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [63:0] a, b;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7};

    rst_l = 1'b0;
    req_valid = 1'b0; bus_a = '0; bus_b = '0; ctrl = '0; resp_ready = 1'b0;
    req_valid0 = 1'b0; bus_a0 = '0; bus_b0 = '0; ctrl0 = '0; resp_ready0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busw", bus_w, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    send(1'b0, 4'h0, 64'h21389, 64'h12398, '{64'h388, 1'b0, 1'b0});
    recv(1'b0, "and", 1, 0);

    send(1'b0, 4'h6, 64'h9231, 64'h8128789, '{64'hFFFFFFFFF7EE0AA8, 1'b0, 1'b0});
    recv(1'b0, "sub", 1, 0);
    send(1'b0, 4'h6, 64'hFFFA, 64'hFFFA, '{64'h0, 1'b1, 1'b0});
    recv(1'b0, "sub_zero", 1, 0);

    send(1'b0, 4'h3, 64'h10, 64'h20, '{64'h200, 1'b0, 1'b0});
    recv(1'b0, "mul", 65, 0);
    send(1'b0, 4'h3, 64'hFFFFFFFFFFFFFFFF, 64'h2, '{64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0});
    recv(1'b0, "mul_wrap", 65, 0);

    send(1'b0, 4'h2, 64'h2387, 64'h9812, '{64'hBB99, 1'b0, 1'b0});
    recv(1'b0, "add_hold", 1, 5);

    send(1'b0, 4'h5, 64'h1234, 64'h5678, '{64'h0, 1'b1, 1'b1});
    recv(1'b0, "illegal", 1, 0);
    send(1'b0, 4'h1, 64'hF0, 64'h0F, '{64'hFF, 1'b0, 1'b0});
    recv(1'b0, "or", 1, 0);

    for (int i = 0; i < 6; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      e  = model(op, a, b, 1'b1);
      send(1'b0, op, a, b, e);
      recv(1'b0, "rand", (op == 4'h3) ? 65 : 1, 0);
    end

    send(1'b1, 4'h3, 64'h5, 64'h7, '{64'h0, 1'b1, 1'b1});
    recv(1'b1, "mul_disabled", 1, 0);
    send(1'b1, 4'h2, 64'h3, 64'h4, '{64'h7, 1'b0, 1'b0});
    recv(1'b1, "nomul_add", 1, 0);

    // Reset in the middle of a MUL, with RespReady high on the same edge.
    send(1'b0, 4'h7, 64'h0, 64'h1234, '{64'h1234, 1'b0, 1'b0});
    recv(1'b0, "passb_pre", 1, 0);
    send(1'b0, 4'h3, 64'h5, 64'h7, '{64'd35, 1'b0, 1'b0});
    repeat (29) @(negedge clk);
    rst_l = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    resp_ready = 1'b0;
    sb.delete();
    chk("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("abort_busw", bus_w, 64'd0);
    chk("abort_zero", {63'd0, zero}, 64'd1);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    repeat (70) @(negedge clk);
    chk("abort_no_resp", {63'd0, resp_valid}, 64'd0);
    send(1'b0, 4'h7, 64'h0, 64'h8799BC, '{64'h8799BC, 1'b0, 1'b0});
    recv(1'b0, "passb_post", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
